// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: tag width default, queue depth default, result field widths.
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif

package cdb_arbiter_pkg;

    localparam int CDB_DEPTH = 4;
    localparam int VALUE_W   = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    // One slot of headroom: a result arrives a cycle after the dispatch that saw "not full".
    function automatic logic near_full(input int count, input int depth);
        return count >= depth - 1;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Circular result queue for one CDB producer; push/pop/flush gated by en, 1-cycle update.
// Pushes while full are ignored; head_dat is the stored head (not meaningful when count is 0).
module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_MAX = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok  = push && (count != CNT_MAX);
    assign pop_ok   = pop && (count != '0);
    assign head_dat = mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (en) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push_ok) tail <= tail + 1'b1;
                if (pop_ok)  head <= head + 1'b1;
                case ({push_ok, pop_ok})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && en && !flush && push_ok) mem[tail] <= push_dat;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Serialises ALU/LSB results onto one registered CDB (1 cycle from winning head); *_full at count>=DEPTH-1.
// Fixed LSB-over-ALU priority by default; CDB_RR_EN selects a flip-on-contention round-robin.
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = CDB_DEPTH,
    parameter int ROB_W = `ROB_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear,
    input  logic             alu_ready,
    input  logic [ROB_W-1:0] alu_rob_id,
    input  logic [31:0]      alu_value,
    output logic             alu_full,
    input  logic             lsb_ready,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic [31:0]      lsb_value,
    output logic             lsb_full,
    output logic             cdb_ready,
    output logic [ROB_W-1:0] cdb_rob_id,
    output logic [31:0]      cdb_value
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ROB_W + VALUE_W;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [CW-1:0] alu_cnt, lsb_cnt;
    logic [EW-1:0] alu_head, lsb_head;
    logic [EW-1:0] alu_src, lsb_src;
    logic          alu_has_q, lsb_has_q;
    logic          alu_eff, lsb_eff;
    logic          alu_win, lsb_win;
    logic          alu_push, lsb_push;
    logic          alu_pop, lsb_pop;

    assign alu_has_q = (alu_cnt != '0);
    assign lsb_has_q = (lsb_cnt != '0);
    assign alu_eff   = alu_has_q || alu_ready;
    assign lsb_eff   = lsb_has_q || lsb_ready;
    assign alu_src   = alu_has_q ? alu_head : {alu_rob_id, alu_value};
    assign lsb_src   = lsb_has_q ? lsb_head : {lsb_rob_id, lsb_value};

`ifdef CDB_RR_EN
    src_e pref;

    assign lsb_win = lsb_eff && (!alu_eff || pref == SRC_LSB);
    assign alu_win = alu_eff && !lsb_win;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pref <= SRC_LSB;
        end else if (rdy_in && !clear && alu_eff && lsb_eff) begin
            pref <= (pref == SRC_LSB) ? SRC_ALU : SRC_LSB;
        end
    end
`else
    assign lsb_win = lsb_eff;
    assign alu_win = alu_eff && !lsb_eff;
`endif

    // A winning input with an empty queue is bypassed straight to the CDB and never stored.
    assign alu_pop  = alu_win && alu_has_q;
    assign lsb_pop  = lsb_win && lsb_has_q;
    assign alu_push = alu_ready && (alu_cnt != CNT_MAX) && !(alu_win && !alu_has_q);
    assign lsb_push = lsb_ready && (lsb_cnt != CNT_MAX) && !(lsb_win && !lsb_has_q);

    assign alu_full = near_full(int'(alu_cnt), DEPTH);
    assign lsb_full = near_full(int'(lsb_cnt), DEPTH);

    cdb_fifo #(.DEPTH(DEPTH), .W(EW)) u_alu_q (
        .clk      (clk_in),
        .rst      (rst_in),
        .en       (rdy_in),
        .flush    (clear),
        .push     (alu_push),
        .push_dat ({alu_rob_id, alu_value}),
        .pop      (alu_pop),
        .head_dat (alu_head),
        .count    (alu_cnt)
    );

    cdb_fifo #(.DEPTH(DEPTH), .W(EW)) u_lsb_q (
        .clk      (clk_in),
        .rst      (rst_in),
        .en       (rdy_in),
        .flush    (clear),
        .push     (lsb_push),
        .push_dat ({lsb_rob_id, lsb_value}),
        .pop      (lsb_pop),
        .head_dat (lsb_head),
        .count    (lsb_cnt)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cdb_ready  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                cdb_ready <= 1'b0;
            end else begin
                cdb_ready <= alu_win || lsb_win;
                if (lsb_win) begin
                    {cdb_rob_id, cdb_value} <= lsb_src;
                end else if (alu_win) begin
                    {cdb_rob_id, cdb_value} <= alu_src;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int RW = 5;
    localparam int D  = 4;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, clear;
    logic          alu_ready, lsb_ready;
    logic [RW-1:0] alu_rob_id, lsb_rob_id;
    logic [31:0]   alu_value, lsb_value;
    logic          alu_full, lsb_full;
    logic          cdb_ready;
    logic [RW-1:0] cdb_rob_id;
    logic [31:0]   cdb_value;

    cdb_arbiter #(.DEPTH(D), .ROB_W(RW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .alu_ready(alu_ready), .alu_rob_id(alu_rob_id), .alu_value(alu_value), .alu_full(alu_full),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value), .lsb_full(lsb_full),
        .cdb_ready(cdb_ready), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int n_viol  = 0;

    // Reference model: one FIFO queue per source plus the expected CDB register.
    logic [RW+31:0] mq_a[$];
    logic [RW+31:0] mq_l[$];
    bit             pref_lsb = 1'b1;
    logic           e_v = 1'b0;
    logic [RW-1:0]  e_id = '0;
    logic [31:0]    e_val = '0;
    bit             rec = 1'b0;
    int             seen[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit rd, input bit cl,
                       input bit av, input int aid, input logic [31:0] aval,
                       input bit lv, input int lid, input logic [31:0] lval);
        bit ha, hl, wa, wl;
        logic [RW+31:0] w;
        rst_in = r; rdy_in = rd; clear = cl;
        alu_ready = av; alu_rob_id = aid[RW-1:0]; alu_value = aval;
        lsb_ready = lv; lsb_rob_id = lid[RW-1:0]; lsb_value = lval;
        if (r) begin
            mq_a.delete(); mq_l.delete();
            e_v = 1'b0; e_id = '0; e_val = '0; pref_lsb = 1'b1;
        end else if (rd && cl) begin
            mq_a.delete(); mq_l.delete();
            e_v = 1'b0;
        end else if (rd) begin
            if (av && mq_a.size() == D) begin n_viol++; av = 1'b0; end
            if (lv && mq_l.size() == D) begin n_viol++; lv = 1'b0; end
            ha = (mq_a.size() > 0) || av;
            hl = (mq_l.size() > 0) || lv;
`ifdef CDB_RR_EN
            wl = hl && (!ha || pref_lsb);
            if (ha && hl) pref_lsb = !pref_lsb;
`else
            wl = hl;
`endif
            wa = ha && !wl;
            if (av) mq_a.push_back({aid[RW-1:0], aval});
            if (lv) mq_l.push_back({lid[RW-1:0], lval});
            e_v = wa || wl;
            if (wl) begin w = mq_l.pop_front(); {e_id, e_val} = w; end
            if (wa) begin w = mq_a.pop_front(); {e_id, e_val} = w; end
        end
        @(negedge clk_in);
        check_eq("cdb_ready", cdb_ready, e_v);
        check_eq("cdb_rob_id", cdb_rob_id, e_id);
        check_eq("cdb_value", cdb_value, e_val);
        check_eq("alu_full", alu_full, mq_a.size() >= D - 1);
        check_eq("lsb_full", lsb_full, mq_l.size() >= D - 1);
        if (rec && cdb_ready) seen.push_back(int'(cdb_rob_id));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pair(input int aid, input int lid);
        cyc(0, 1, 0, 1, aid, 32'h100 + aid, 1, lid, 32'h200 + lid);
    endtask

    initial begin
        int exp3[6];
        int alu_seen[$];
        rst_in = 1'b1; rdy_in = 1'b0; clear = 1'b0;
        alu_ready = 1'b0; alu_rob_id = '0; alu_value = '0;
        lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = '0;
        @(negedge clk_in);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("rst_cdb_ready", cdb_ready, 0);
        check_eq("rst_cdb_rob_id", cdb_rob_id, 0);
        check_eq("rst_cdb_value", cdb_value, 0);
        check_eq("rst_full", {alu_full, lsb_full}, 0);

        // Single ALU result: visible for exactly one cycle, one register of latency.
        cyc(0, 1, 0, 1, 3, 32'h11, 0, 0, 0);
        check_eq("single_rdy", cdb_ready, 1);
        check_eq("single_tag", cdb_rob_id, 3);
        check_eq("single_val", cdb_value, 32'h11);
        check_eq("single_full", alu_full, 0);
        idle(1);
        check_eq("single_once", cdb_ready, 0);

        // Simultaneous pair: LSB first in both policies from the reset pointer.
        seen.delete(); rec = 1'b1;
        pair(1, 2);
        idle(3);
        rec = 1'b0;
        check_eq("pair_cnt", seen.size(), 2);
        if (seen.size() == 2) begin
            check_eq("pair_first", seen[0], 2);
            check_eq("pair_second", seen[1], 1);
        end

        // Three back-to-back pairs from reset.
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        seen.delete(); rec = 1'b1;
        pair(1, 2); pair(3, 4); pair(5, 6);
        idle(7);
        rec = 1'b0;
`ifdef CDB_RR_EN
        exp3 = '{2, 1, 4, 3, 6, 5};
`else
        exp3 = '{2, 4, 6, 1, 3, 5};
`endif
        check_eq("seq3_cnt", seen.size(), 6);
        for (int i = 0; i < 6 && i < seen.size(); i++) check_eq("seq3_order", seen[i], exp3[i]);

        // ALU burst under continuous LSB traffic.
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        seen.delete(); rec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 1, 10 + i, 32'h300 + i, 1, 20 + i, 32'h400 + i);
`ifndef CDB_RR_EN
            if (i == 2) check_eq("burst_full_rise", alu_full, 1);
`endif
        end
        for (int i = 4; i < 7; i++) cyc(0, 1, 0, 0, 0, 0, 1, 20 + i, 32'h400 + i);
        idle(8);
        rec = 1'b0;
        foreach (seen[i]) if (seen[i] >= 10 && seen[i] < 14) alu_seen.push_back(seen[i]);
        check_eq("burst_alu_cnt", alu_seen.size(), 4);
        for (int i = 0; i < 4 && i < alu_seen.size(); i++) check_eq("burst_alu_order", alu_seen[i], 10 + i);

        // Flush with queued results: nothing queued may ever appear.
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        pair(1, 2); pair(3, 4); pair(5, 6);
        seen.delete(); rec = 1'b1;
        cyc(0, 1, 1, 1, 7, 32'h77, 1, 8, 32'h88);
        check_eq("clear_rdy", cdb_ready, 0);
        check_eq("clear_full", {alu_full, lsb_full}, 0);
        idle(6);
        rec = 1'b0;
        check_eq("clear_no_bcast", seen.size(), 0);

        // Stall with queued results: everything frozen, then resumes.
        pair(9, 10); pair(11, 12); pair(13, 14);
        for (int i = 0; i < 5; i++)
            cyc(0, 0, i == 2, 1, 15 + i, $urandom, 1, 20 + i, $urandom);
        idle(8);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bit r, rd, cl, av, lv;
            r  = ($urandom % 600) == 0;
            rd = ($urandom % 8) != 0;
            cl = ($urandom % 80) == 0;
            av = ($urandom % 2) && (mq_a.size() < D);
            lv = ($urandom % 3 == 0) && (mq_l.size() < D);
            cyc(r, rd, cl, av, $urandom % 32, $urandom, lv, $urandom % 32, $urandom);
        end
        idle(10);
        check_eq("protocol_viol", n_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
